// File: rtl/mc_ctrl_if.sv
// Memory request/acknowledge bundle between the mc_ctrl sequencer and
// the shared instruction/data memory.
interface mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_iord;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_iord, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_iord, output mem_ack);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/memory/write-back
// FSM with a req/ack memory handshake and combinational control outputs.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  mc_ctrl_if.master  mem,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_b,
  output logic       ext_op,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       bad_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXE_R   = 4'd3,
    S_EXE_I   = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_WB      = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  state_t state_q, state_d;

  logic is_rtype, is_addu, is_subu, is_slt, is_jr;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

  // IR is stable after FETCH, so decoding it every cycle is safe.
  always_comb begin
    is_rtype = (opcode == 6'b000000);
    is_addu  = is_rtype && (funct == 6'b100001);
    is_subu  = is_rtype && (funct == 6'b100011);
    is_slt   = is_rtype && (funct == 6'b101010);
    is_jr    = is_rtype && (funct == 6'b001000);
    is_ori   = (opcode == 6'b001101);
    is_lui   = (opcode == 6'b001111);
    is_lw    = (opcode == 6'b100011);
    is_sw    = (opcode == 6'b101011);
    is_beq   = (opcode == 6'b000100);
    is_j     = (opcode == 6'b000010);
    is_jal   = (opcode == 6'b000011);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d      = state_q;
    pc_wr        = 1'b0;
    pc_src       = 2'b00;
    ir_wr        = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_iord = 1'b0;
    reg_wr       = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    alu_src_b    = 1'b0;
    ext_op       = 1'b0;
    alu_op       = ALU_ADD;
    instr_done   = 1'b0;
    bad_instr    = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_addu || is_subu || is_slt)       state_d = S_EXE_R;
        else if (is_jr || is_j || is_jal)       state_d = S_JUMP;
        else if (is_ori || is_lui)              state_d = S_EXE_I;
        else if (is_lw || is_sw)                state_d = S_MEM_ADR;
        else if (is_beq)                        state_d = S_BRANCH;
        else begin
          bad_instr = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_EXE_R: begin
        alu_op  = is_subu ? ALU_SUB : (is_slt ? ALU_SLT : ALU_ADD);
        reg_dst = 2'b01;
        state_d = S_WB;
      end

      S_EXE_I: begin
        alu_src_b = 1'b1;
        alu_op    = is_lui ? ALU_LUI : ALU_OR;
        state_d   = S_WB;
      end

      // Destination is re-derived from the still-valid opcode rather than
      // being registered in the execute state.
      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = is_rtype ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_ADR: begin
        alu_src_b = 1'b1;
        ext_op    = 1'b1;
        state_d   = is_sw ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem.mem_req  = 1'b1;
        mem.mem_iord = 1'b1;
        if (mem.mem_ack) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem.mem_req  = 1'b1;
        mem.mem_iord = 1'b1;
        mem.mem_we   = 1'b1;
        if (mem.mem_ack) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_BRANCH: begin
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        pc_wr      = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pc_wr      = 1'b1;
        instr_done = 1'b1;
        pc_src     = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          reg_wr     = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed scoreboard bench for mc_ctrl: each step queues the expected state
// and packed control word, which are popped and checked at the falling edge.
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_wr, ir_wr, reg_wr, alu_src_b, ext_op, instr_done, bad_instr;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [18:0] obs;

  int checks = 0;
  int errors = 0;

  mc_ctrl_if mif ();

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem(mif), .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .instr_done(instr_done), .bad_instr(bad_instr), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {pc_wr, pc_src, ir_wr, mif.mem_req, mif.mem_we, mif.mem_iord,
                reg_wr, reg_dst, mem_to_reg, alu_src_b, ext_op, alu_op,
                instr_done, bad_instr};

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [18:0] o;
  } exp_t;
  exp_t sb[$];

  function automatic logic [18:0] o(
    input logic pcw, input logic [1:0] pcs, input logic irw, input logic req,
    input logic we, input logic iord, input logic rw, input logic [1:0] rd,
    input logic [1:0] m2r, input logic asb, input logic ext,
    input logic [2:0] aop, input logic done, input logic bad);
    return {pcw, pcs, irw, req, we, iord, rw, rd, m2r, asb, ext, aop, done, bad};
  endfunction

  localparam logic [18:0] NONE = '0;

  task automatic push(input string tag, input logic [3:0] st, input logic [18:0] ov);
    exp_t e;
    e.tag = tag; e.st = st; e.o = ov;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty got no expectation want one");
    end else begin
      e = sb.pop_front();
      assert (state === e.st) else begin
        errors++;
        $error("FAIL %s state got %0d want %0d", e.tag, state, e.st);
      end
      checks++;
      assert (obs === e.o) else begin
        errors++;
        $error("FAIL %s outs got %b want %b", e.tag, obs, e.o);
      end
    end
  endtask

  // One clock: expectation queued now, checked at the falling edge,
  // returns just after the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [18:0] ov);
    push(tag, st, ov);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_now(input string tag, input logic [3:0] st, input logic [18:0] ov);
    push(tag, st, ov);
    pop_check();
  endtask

  task automatic fetch_dec(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [18:0] dec_o);
    opcode = op; funct = fn; mif.mem_ack = 1'b1;
    cyc({tag, "_fetch"}, 4'd1, o(1,2'b00,1,1,0,0,0,2'b00,2'b00,0,0,3'b000,0,0));
    cyc({tag, "_dec"}, 4'd2, dec_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog state got %0d want finish", state);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mif.mem_ack = 1'b1;

    // 1: reset, release, fetch with immediate ack, then addu
    cyc("in_reset", 4'd0, NONE);
    rst = 1'b0;
    cyc("reset_st", 4'd0, NONE);
    fetch_dec("addu", 6'b000000, 6'b100001, NONE);
    cyc("addu_exe", 4'd3, o(0,2'b00,0,0,0,0,0,2'b01,2'b00,0,0,3'b000,0,0));
    cyc("addu_wb",  4'd11, o(0,2'b00,0,0,0,0,1,2'b01,2'b00,0,0,3'b000,1,0));

    // 2: fetch with three wait cycles, then ori
    opcode = 6'b001101; mif.mem_ack = 1'b0;
    for (int unsigned i = 0; i < 3; i++)
      cyc("fetch_wait", 4'd1, o(0,2'b00,0,1,0,0,0,2'b00,2'b00,0,0,3'b000,0,0));
    mif.mem_ack = 1'b1;
    cyc("fetch_ack", 4'd1, o(1,2'b00,1,1,0,0,0,2'b00,2'b00,0,0,3'b000,0,0));
    cyc("ori_dec", 4'd2, NONE);
    cyc("ori_exe", 4'd4, o(0,2'b00,0,0,0,0,0,2'b00,2'b00,1,0,3'b010,0,0));
    cyc("ori_wb",  4'd11, o(0,2'b00,0,0,0,0,1,2'b00,2'b00,0,0,3'b000,1,0));

    // subu, slt, lui execute-stage ALU ops
    fetch_dec("subu", 6'b000000, 6'b100011, NONE);
    cyc("subu_exe", 4'd3, o(0,2'b00,0,0,0,0,0,2'b01,2'b00,0,0,3'b001,0,0));
    cyc("subu_wb",  4'd11, o(0,2'b00,0,0,0,0,1,2'b01,2'b00,0,0,3'b000,1,0));
    fetch_dec("slt", 6'b000000, 6'b101010, NONE);
    cyc("slt_exe", 4'd3, o(0,2'b00,0,0,0,0,0,2'b01,2'b00,0,0,3'b011,0,0));
    cyc("slt_wb",  4'd11, o(0,2'b00,0,0,0,0,1,2'b01,2'b00,0,0,3'b000,1,0));
    fetch_dec("lui", 6'b001111, 6'b000000, NONE);
    cyc("lui_exe", 4'd4, o(0,2'b00,0,0,0,0,0,2'b00,2'b00,1,0,3'b100,0,0));
    cyc("lui_wb",  4'd11, o(0,2'b00,0,0,0,0,1,2'b00,2'b00,0,0,3'b000,1,0));

    // 3: lw with two MEM_RD wait cycles; ack low during MEM_ADR is ignored
    fetch_dec("lw", 6'b100011, 6'b000000, NONE);
    mif.mem_ack = 1'b0;
    cyc("lw_adr", 4'd5, o(0,2'b00,0,0,0,0,0,2'b00,2'b00,1,1,3'b000,0,0));
    cyc("lw_rd_w1", 4'd6, o(0,2'b00,0,1,0,1,0,2'b00,2'b00,0,0,3'b000,0,0));
    cyc("lw_rd_w2", 4'd6, o(0,2'b00,0,1,0,1,0,2'b00,2'b00,0,0,3'b000,0,0));
    mif.mem_ack = 1'b1;
    cyc("lw_rd_ack", 4'd6, o(0,2'b00,0,1,0,1,0,2'b00,2'b00,0,0,3'b000,0,0));
    cyc("lw_wb", 4'd7, o(0,2'b00,0,0,0,0,1,2'b00,2'b01,0,0,3'b000,1,0));

    // 4: beq taken and not taken
    zero = 1'b1;
    fetch_dec("beq_t", 6'b000100, 6'b000000, NONE);
    cyc("beq_t_br", 4'd9, o(1,2'b01,0,0,0,0,0,2'b00,2'b00,0,0,3'b001,1,0));
    zero = 1'b0;
    fetch_dec("beq_n", 6'b000100, 6'b000000, NONE);
    cyc("beq_n_br", 4'd9, o(0,2'b01,0,0,0,0,0,2'b00,2'b00,0,0,3'b001,1,0));

    // 5: jumps and unsupported encodings
    fetch_dec("jal", 6'b000011, 6'b000000, NONE);
    cyc("jal_jmp", 4'd10, o(1,2'b10,0,0,0,0,1,2'b10,2'b10,0,0,3'b000,1,0));
    fetch_dec("jr", 6'b000000, 6'b001000, NONE);
    cyc("jr_jmp", 4'd10, o(1,2'b11,0,0,0,0,0,2'b00,2'b00,0,0,3'b000,1,0));
    fetch_dec("j", 6'b000010, 6'b000000, NONE);
    cyc("j_jmp", 4'd10, o(1,2'b10,0,0,0,0,0,2'b00,2'b00,0,0,3'b000,1,0));
    fetch_dec("bad_op", 6'b111111, 6'b000000,
              o(0,2'b00,0,0,0,0,0,2'b00,2'b00,0,0,3'b000,0,1));
    fetch_dec("bad_fn", 6'b000000, 6'b100000,
              o(0,2'b00,0,0,0,0,0,2'b00,2'b00,0,0,3'b000,0,1));

    // sw with one wait cycle
    fetch_dec("sw", 6'b101011, 6'b000000, NONE);
    cyc("sw_adr", 4'd5, o(0,2'b00,0,0,0,0,0,2'b00,2'b00,1,1,3'b000,0,0));
    mif.mem_ack = 1'b0;
    cyc("sw_wr_w", 4'd8, o(0,2'b00,0,1,1,1,0,2'b00,2'b00,0,0,3'b000,0,0));
    mif.mem_ack = 1'b1;
    cyc("sw_wr_ack", 4'd8, o(0,2'b00,0,1,1,1,0,2'b00,2'b00,0,0,3'b000,1,0));

    // 6: reset asserted mid-cycle during an outstanding MEM_WR request
    fetch_dec("sw2", 6'b101011, 6'b000000, NONE);
    mif.mem_ack = 1'b0;
    cyc("sw2_adr", 4'd5, o(0,2'b00,0,0,0,0,0,2'b00,2'b00,1,1,3'b000,0,0));
    #1;
    chk_now("sw2_wr", 4'd8, o(0,2'b00,0,1,1,1,0,2'b00,2'b00,0,0,3'b000,0,0));
    rst = 1'b1;
    #1;
    chk_now("rst_abort", 4'd0, NONE);
    @(posedge clk); #1;
    rst = 1'b0; mif.mem_ack = 1'b1;
    cyc("rst_restart", 4'd0, NONE);
    fetch_dec("post_rst", 6'b000010, 6'b000000, NONE);
    cyc("post_rst_jmp", 4'd10, o(1,2'b10,0,0,0,0,0,2'b00,2'b00,0,0,3'b000,1,0));
    cyc("post_rst_fetch", 4'd1, o(1,2'b00,1,1,0,0,0,2'b00,2'b00,0,0,3'b000,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
